// File: rtl/sentinel_shell_mc.sv
// Multi-channel instrumentation shell: zero-latency pass-through around NUM_CH cores,
// per-channel ingress tagging, and one shared trace stream merged by a round-robin arbiter.
module sentinel_shell_ch #(
    parameter int CH_ID          = 0,
    parameter int CH_W           = 2,
    parameter int TX_ID_WIDTH    = 32,
    parameter int CYCLE_WIDTH    = 64,
    parameter int OPCODE_WIDTH   = 8,
    parameter int INFLIGHT_DEPTH = 16,
    localparam int REC_W = CH_W + TX_ID_WIDTH + 2*CYCLE_WIDTH + OPCODE_WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ing,
    input  logic                    egr,
    input  logic                    en,
    input  logic                    err,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [CYCLE_WIDTH-1:0]  cyc,
    input  logic                    grant,
    output logic                    stg_vld,
    output logic [REC_W-1:0]        stg_rec,
    output logic                    drop,
    output logic                    ovf,
    output logic                    unf
);
    localparam int AW = $clog2(INFLIGHT_DEPTH);
    localparam int EW = TX_ID_WIDTH + CYCLE_WIDTH + OPCODE_WIDTH;

    logic [EW-1:0]           mem [INFLIGHT_DEPTH];
    logic [AW-1:0]           wp, rp;
    logic [AW:0]             cnt;
    logic [TX_ID_WIDTH-1:0]  tx_id, h_tx;
    logic [CYCLE_WIDTH-1:0]  h_t;
    logic [OPCODE_WIDTH-1:0] h_op;
    logic                    empty, full, push, pop, rec_v;
    logic [REC_W-1:0]        rec;

    assign {h_tx, h_t, h_op} = mem[rp];
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(INFLIGHT_DEPTH));
    // Popping ignores en so a disabled channel still drains its tags.
    assign push  = ing && en && !full;
    assign pop   = egr && !empty;
    assign rec_v = egr && en;
    assign ovf   = ing && en && full;
    assign unf   = egr && en && empty;
    assign drop  = rec_v && stg_vld && !grant;
    assign rec   = empty ? {CH_W'(CH_ID), {TX_ID_WIDTH{1'b0}}, {CYCLE_WIDTH{1'b0}}, cyc,
                            {OPCODE_WIDTH{1'b0}}, 2'b00, 1'b1, err}
                         : {CH_W'(CH_ID), h_tx, h_t, cyc, h_op, 2'b00, 1'b0, err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            tx_id   <= '0;
            stg_vld <= 1'b0;
            stg_rec <= '0;
        end else begin
            if (ing)  tx_id <= tx_id + TX_ID_WIDTH'(1);
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (rec_v && (!stg_vld || grant)) begin
                stg_vld <= 1'b1;
                stg_rec <= rec;
            end else if (grant) begin
                stg_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {tx_id, cyc, opcode};
    end
endmodule

module sentinel_shell_mc #(
    parameter int NUM_CH           = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int OPCODE_WIDTH     = 8,
    parameter int TX_ID_WIDTH      = 32,
    parameter int CYCLE_WIDTH      = 64,
    parameter int INFLIGHT_DEPTH   = 16,
    parameter int TRACE_FIFO_DEPTH = 64,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              in_valid,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_CH*OPCODE_WIDTH-1:0] in_opcode,
    output logic [NUM_CH-1:0]              out_valid,
    input  logic [NUM_CH-1:0]              out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
    output logic [NUM_CH-1:0]              core_in_valid,
    input  logic [NUM_CH-1:0]              core_in_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   core_in_data,
    input  logic [NUM_CH-1:0]              core_out_valid,
    output logic [NUM_CH-1:0]              core_out_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   core_out_data,
    input  logic [NUM_CH-1:0]              core_error,
    input  logic [NUM_CH-1:0]              trace_en,
    output logic                           trace_valid,
    input  logic                           trace_ready,
    output logic [CH_W-1:0]                trace_ch,
    output logic [TX_ID_WIDTH-1:0]         trace_tx_id,
    output logic [CYCLE_WIDTH-1:0]         trace_t_ingress,
    output logic [CYCLE_WIDTH-1:0]         trace_t_egress,
    output logic [OPCODE_WIDTH-1:0]        trace_opcode,
    output logic [3:0]                     trace_flags,
    output logic [CYCLE_WIDTH-1:0]         cycle_counter,
    output logic [63:0]                    trace_drop_count,
    output logic [31:0]                    inflight_overflow_count,
    output logic [31:0]                    inflight_underflow_count,
    output logic                           trace_overflow_seen
);
    localparam int REC_W = CH_W + TX_ID_WIDTH + 2*CYCLE_WIDTH + OPCODE_WIDTH + 4;
    localparam int TAW   = $clog2(TRACE_FIFO_DEPTH);

    assign core_in_valid  = in_valid;
    assign core_in_data   = in_data;
    assign in_ready       = core_in_ready;
    assign out_valid      = core_out_valid;
    assign out_data       = core_out_data;
    assign core_out_ready = out_ready;

    logic [NUM_CH-1:0]            ing, egr, gnt, stg_vld, drop, ovf, unf;
    logic [NUM_CH-1:0][REC_W-1:0] stg_rec;

    assign ing = in_valid & core_in_ready;
    assign egr = core_out_valid & out_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sentinel_shell_ch #(
            .CH_ID(c), .CH_W(CH_W), .TX_ID_WIDTH(TX_ID_WIDTH), .CYCLE_WIDTH(CYCLE_WIDTH),
            .OPCODE_WIDTH(OPCODE_WIDTH), .INFLIGHT_DEPTH(INFLIGHT_DEPTH)
        ) u_ch (
            .clk(clk), .rst_n(rst_n), .ing(ing[c]), .egr(egr[c]), .en(trace_en[c]),
            .err(core_error[c]), .opcode(in_opcode[c*OPCODE_WIDTH +: OPCODE_WIDTH]),
            .cyc(cycle_counter), .grant(gnt[c]), .stg_vld(stg_vld[c]), .stg_rec(stg_rec[c]),
            .drop(drop[c]), .ovf(ovf[c]), .unf(unf[c])
        );
    end

    logic [REC_W-1:0] tf_mem [TRACE_FIFO_DEPTH];
    logic [TAW-1:0]   tf_wp, tf_rp;
    logic [TAW:0]     tf_cnt;
    logic             tf_full, tf_pop, gnt_any;
    logic [CH_W-1:0]  last_gnt, gnt_idx;

    assign tf_full     = (tf_cnt == (TAW+1)'(TRACE_FIFO_DEPTH));
    assign trace_valid = (tf_cnt != '0);
    assign tf_pop      = trace_valid && trace_ready;
    assign {trace_ch, trace_tx_id, trace_t_ingress, trace_t_egress, trace_opcode, trace_flags} = tf_mem[tf_rp];

    // Round-robin: scan from last_gnt+1, wrapping, and take the first staged record.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = last_gnt;
        if (!tf_full) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                if (!gnt_any && stg_vld[(int'(last_gnt) + i) % NUM_CH]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CH_W'((int'(last_gnt) + i) % NUM_CH);
                    gnt[(int'(last_gnt) + i) % NUM_CH] = 1'b1;
                end
            end
        end
    end

    logic [CH_W:0] n_drop, n_ovf, n_unf;
    always_comb begin
        n_drop = '0;
        n_ovf  = '0;
        n_unf  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            n_drop = n_drop + (CH_W+1)'(drop[c]);
            n_ovf  = n_ovf  + (CH_W+1)'(ovf[c]);
            n_unf  = n_unf  + (CH_W+1)'(unf[c]);
        end
    end

    logic [32:0] ovf_sum, unf_sum;
    assign ovf_sum = {1'b0, inflight_overflow_count}  + 33'(n_ovf);
    assign unf_sum = {1'b0, inflight_underflow_count} + 33'(n_unf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_wp                    <= '0;
            tf_rp                    <= '0;
            tf_cnt                   <= '0;
            last_gnt                 <= '0;
            cycle_counter            <= '0;
            trace_drop_count         <= '0;
            inflight_overflow_count  <= '0;
            inflight_underflow_count <= '0;
            trace_overflow_seen      <= 1'b0;
        end else begin
            cycle_counter <= cycle_counter + CYCLE_WIDTH'(1);
            if (gnt_any) begin
                tf_wp    <= tf_wp + TAW'(1);
                last_gnt <= gnt_idx;
            end
            if (tf_pop) tf_rp <= tf_rp + TAW'(1);
            tf_cnt <= tf_cnt + (TAW+1)'(gnt_any) - (TAW+1)'(tf_pop);
            trace_drop_count         <= trace_drop_count + 64'(n_drop);
            inflight_overflow_count  <= ovf_sum[32] ? '1 : ovf_sum[31:0];
            inflight_underflow_count <= unf_sum[32] ? '1 : unf_sum[31:0];
            if (|drop) trace_overflow_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any) tf_mem[tf_wp] <= stg_rec[gnt_idx];
    end
endmodule
